// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
//   Shared types and constants for the sequential Booth multiplier.
//   - XLEN  : operand width (fixed by the 32-bit cla_32 datapath)
//   - ITERS : Booth iterations over the 33-bit extended operands
//   - CNT_W : iteration counter width (2**CNT_W > ITERS)
//   - state_e : controller states
//   - BOOTH_ADD / BOOTH_SUB : {mplier[0], q_m1} pair encodings
package mul_seq_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 33;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mul_seq_32_cla.sv
// cla_32
//   32-bit carry-lookahead adder: eight 4-bit lookahead blocks whose block
//   generate/propagate terms are chained at the second level.
// Ports:
//   a, b   in  32  addends
//   c_in   in  1   carry in
//   s      out 32  a + b + c_in (mod 2^32)
//   g_out  out 1   group generate over all 32 bits (independent of c_in)
//   p_out  out 1   group propagate over all 32 bits
//   Carry out of bit 31 is g_out | (p_out & c_in).
module cla_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] s,
    output logic        g_out,
    output logic        p_out
);

    logic [31:0] g, p, c;
    logic [7:0]  bg, bp;
    logic [8:0]  bc;
    logic        grp_g;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        bg = '0;
        bp = '0;
        bc = '0;
        c  = '0;

        // block generate/propagate
        for (int k = 0; k < 8; k++) begin
            bg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            bp[k] = &p[4*k +: 4];
        end

        // block carries
        bc[0] = c_in;
        for (int k = 0; k < 8; k++) begin
            bc[k+1] = bg[k] | (bp[k] & bc[k]);
        end

        // bit carries inside each block, all looked ahead from the block carry-in
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
    end

    always_comb begin
        grp_g = 1'b0;
        for (int k = 0; k < 8; k++) begin
            grp_g = bg[k] | (bp[k] & grp_g);
        end
    end

    assign s     = p ^ c;
    assign g_out = grp_g;
    assign p_out = &bp;

endmodule

// File: rtl/mul_seq_32.sv
// mul_seq_32
//   Sequential 32x32->64 radix-2 Booth multiplier for the EX stage.
//   Operands are sign/zero-extended to 33 bits and processed in 33
//   iterations through one shared cla_32; bit 32 of each add is formed
//   inline from the adder's group generate/propagate.
// Ports:
//   clk     in  1   rising-edge clock
//   clrn    in  1   async active-low reset
//   start   in  1   request, sampled only in IDLE
//   sign    in  1   1 = mult (signed), 0 = multu; captured with start
//   a, b    in  32  multiplicand / multiplier; captured with start
//   cancel  in  1   flush; aborts RUN, ignored in DONE (already committed)
//   busy    out 1   RUN or DONE; feeds the pipeline stall
//   done    out 1   one-cycle pulse, hi/lo just written
//   hi, lo  out 32  product[63:32] / product[31:0], held until next done
module mul_seq_32
    import mul_seq_pkg::*;
(
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic            sign,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    acc_q, mcand_q, mplier_q;
    logic             q_m1_q;

    logic             accept;
    logic [1:0]       pair;
    logic             is_add, is_sub;
    logic [XLEN:0]    bop;
    logic [XLEN-1:0]  sum_lo;
    logic             g_out, p_out, c32, sum_hi;
    logic [XLEN:0]    acc_nxt;

    assign accept = (state_q == IDLE) && start && !cancel;
    assign busy   = (state_q != IDLE);

    // ---------------- Booth datapath ----------------
    assign pair   = {mplier_q[0], q_m1_q};
    assign is_add = (pair == BOOTH_ADD);
    assign is_sub = (pair == BOOTH_SUB);
    // subtract as acc + ~mcand + 1
    assign bop    = is_sub ? ~mcand_q : mcand_q;

    cla_32 u_cla (
        .a     (acc_q[XLEN-1:0]),
        .b     (bop[XLEN-1:0]),
        .c_in  (is_sub),
        .s     (sum_lo),
        .g_out (g_out),
        .p_out (p_out)
    );

    // extend the 32-bit add to 33 bits: carry into bit 32, then its sum bit
    assign c32     = g_out | (p_out & is_sub);
    assign sum_hi  = acc_q[XLEN] ^ bop[XLEN] ^ c32;
    assign acc_nxt = (is_add || is_sub) ? {sum_hi, sum_lo} : acc_q;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cancel) state_d = IDLE;
                     else if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- operand / accumulator registers ----------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            q_m1_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            acc_q    <= '0;
            mcand_q  <= {sign & a[XLEN-1], a};
            mplier_q <= {sign & b[XLEN-1], b};
            q_m1_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            // arithmetic shift right of {acc_nxt, mplier, q_m1}
            acc_q    <= {acc_nxt[XLEN], acc_nxt[XLEN:1]};
            mplier_q <= {acc_nxt[0], mplier_q[XLEN:1]};
            q_m1_q   <= mplier_q[0];
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // ---------------- result registers ----------------
    // {acc, mplier} holds the 66-bit product; its low 64 bits are exact.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            done <= (state_q == DONE);
            if (state_q == DONE) begin
                hi <= {acc_q[XLEN-2:0], mplier_q[XLEN]};
                lo <= mplier_q[XLEN-1:0];
            end
        end
    end

endmodule
